// File: rtl/mdr_mem_reader.sv
// mdr_mem_reader: memory data register with two sources.
// A memory read is started by rd_start. The read strobe stays up until
// mem_ready arrives or the wait budget runs out. Captured data lands in the
// MDR, which is driven straight onto BusMuxIn. While idle, the MDR can also
// be loaded directly from BusMuxOut. Every output comes from a flop.
module mdr_mem_reader #(
  parameter int WIDTH   = 32,
  parameter int AW      = 9,
  parameter int TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             rd_start,
  input  logic [AW-1:0]    rd_addr,
  input  logic             bus_load,
  input  logic [WIDTH-1:0] BusMuxOut,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_rd,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] BusMuxIn,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  // Wide enough to hold TIMEOUT, so the counter can never wrap.
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] mdr_n;
  logic [AW-1:0]    addr_n;
  logic             rd_n, busy_n, done_n, to_n;

  // State and all output registers; a low clear overrides every input.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state    <= S_IDLE;
      cnt      <= '0;
      BusMuxIn <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      BusMuxIn <= mdr_n;
      mem_addr <= addr_n;
      mem_rd   <= rd_n;
      busy     <= busy_n;
      done     <= done_n;
      timeout  <= to_n;
    end
  end

  // Next-state and next-output logic. done and timeout are single-cycle
  // pulses, so they default low on every cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mdr_n   = BusMuxIn;
    addr_n  = mem_addr;
    rd_n    = mem_rd;
    busy_n  = busy;
    done_n  = 1'b0;
    to_n    = 1'b0;
    case (state)
      S_IDLE: begin
        // A read request takes priority; a bus load in the same cycle is dropped.
        if (rd_start) begin
          addr_n  = rd_addr;
          rd_n    = 1'b1;
          busy_n  = 1'b1;
          cnt_n   = '0;
          state_n = S_WAIT;
        end else if (bus_load) begin
          mdr_n = BusMuxOut;
        end
      end
      S_WAIT: begin
        // If data arrives on the last allowed cycle, the data wins over the abort.
        if (mem_ready) begin
          mdr_n   = mem_rdata;
          done_n  = 1'b1;
          rd_n    = 1'b0;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            to_n    = 1'b1;
            rd_n    = 1'b0;
            busy_n  = 1'b0;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mdr_mem_reader.sv
// Bench for mdr_mem_reader: directed scenarios followed by random traffic.
// The reference model describes a read as "pending for N cycles so far".
// Each cycle, every output is compared against that model.
module tb_mdr_mem_reader;
  localparam int WIDTH   = 32;
  localparam int AW      = 9;
  localparam int TIMEOUT = 15;

  logic             clock = 1'b0;
  logic             clear;
  logic             rd_start;
  logic [AW-1:0]    rd_addr;
  logic             bus_load;
  logic [WIDTH-1:0] BusMuxOut;
  logic             mem_ready;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_rd;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] BusMuxIn;
  logic             busy;
  logic             done;
  logic             timeout;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  bit               m_pending;
  int               m_waited;
  logic [AW-1:0]    m_addr;
  logic [WIDTH-1:0] m_mdr;
  bit               m_done, m_to;

  mdr_mem_reader #(.WIDTH(WIDTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .clear(clear), .rd_start(rd_start), .rd_addr(rd_addr),
    .bus_load(bus_load), .BusMuxOut(BusMuxOut), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .BusMuxIn(BusMuxIn), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Update the model with the inputs seen at the current edge.
  task automatic model_edge();
    m_done = 0;
    m_to   = 0;
    if (!clear) begin
      m_pending = 0; m_waited = 0; m_addr = '0; m_mdr = '0;
    end else if (m_pending) begin
      m_waited++;
      if (mem_ready) begin
        m_mdr = mem_rdata; m_done = 1; m_pending = 0;
      end else if (m_waited == TIMEOUT) begin
        m_to = 1; m_pending = 0;
      end
    end else if (rd_start) begin
      m_pending = 1; m_waited = 0; m_addr = rd_addr;
    end else if (bus_load) begin
      m_mdr = BusMuxOut;
    end
  endtask

  // Run one clock, then compare every output 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    chk("mem_rd",   {63'd0, mem_rd},   {63'd0, m_pending});
    chk("busy",     {63'd0, busy},     {63'd0, m_pending});
    chk("done",     {63'd0, done},     {63'd0, m_done});
    chk("timeout",  {63'd0, timeout},  {63'd0, m_to});
    chk("mem_addr", {55'd0, mem_addr}, {55'd0, m_addr});
    chk("BusMuxIn", {32'd0, BusMuxIn}, {32'd0, m_mdr});
  endtask

  task automatic idle_inputs();
    clear = 1; rd_start = 0; bus_load = 0; mem_ready = 0;
  endtask

  initial begin
    int cnt_rd;
    bit seen_to;
    logic [WIDTH-1:0] keep;
    clear = 0; rd_start = 0; rd_addr = '0; bus_load = 0;
    BusMuxOut = '0; mem_ready = 0; mem_rdata = '0;
    m_pending = 0; m_waited = 0; m_addr = '0; m_mdr = '0; m_done = 0; m_to = 0;
    #2;

    // Reset state.
    step();
    chk("reset_busmuxin", {32'd0, BusMuxIn}, 64'd0);
    idle_inputs();
    step();

    // Read 0x01A; data arrives on the 3rd WAIT cycle.
    rd_start = 1; rd_addr = 9'h01A; bus_load = 0;
    step();
    chk("rd_addr_latched", {55'd0, mem_addr}, 64'h01A);
    rd_start = 0;
    cnt_rd = 1;
    step(); if (mem_rd) cnt_rd++;
    step(); if (mem_rd) cnt_rd++;
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    step();
    chk("rd_high_cycles", cnt_rd, 3);
    chk("deadbeef", {32'd0, BusMuxIn}, 64'hDEADBEEF);
    chk("done_pulse", {63'd0, done}, 64'd1);
    idle_inputs();
    step();
    chk("done_one_cycle", {63'd0, done}, 64'd0);

    // Timeout: mem_ready is never asserted.
    keep = BusMuxIn;
    rd_start = 1; rd_addr = 9'h155;
    step();
    rd_start = 0;
    cnt_rd = 0; seen_to = 0;
    if (mem_rd) cnt_rd++;
    for (int i = 0; i < TIMEOUT + 4 && !seen_to; i++) begin
      step();
      if (mem_rd) cnt_rd++;
      if (timeout) seen_to = 1;
    end
    chk("timeout_seen", {63'd0, seen_to}, 64'd1);
    chk("timeout_rd_cycles", cnt_rd, TIMEOUT);
    chk("timeout_mdr_kept", {32'd0, BusMuxIn}, {32'd0, keep});
    step();

    // bus_load while idle.
    bus_load = 1; BusMuxOut = 32'h12345678;
    step();
    chk("bus_load", {32'd0, BusMuxIn}, 64'h12345678);
    chk("bus_load_nodone", {63'd0, done}, 64'd0);

    // bus_load together with rd_start: the read wins, the bus value is dropped.
    bus_load = 1; BusMuxOut = 32'hCAFEF00D; rd_start = 1; rd_addr = 9'h0F0;
    step();
    chk("collide_mdr", {32'd0, BusMuxIn}, 64'h12345678);
    // bus_load during WAIT is ignored.
    rd_start = 0; BusMuxOut = 32'hBADBAD00;
    step();
    mem_ready = 1; mem_rdata = 32'hA5A5_0001; bus_load = 1;
    // Back-to-back: rd_start is raised in the done cycle.
    step();
    chk("wait_busload_ign", {32'd0, BusMuxIn}, 64'hA5A50001);
    bus_load = 0; mem_ready = 0; rd_start = 1; rd_addr = 9'h003;
    step();
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    rd_start = 1; rd_addr = 9'h004; mem_ready = 1; mem_rdata = 32'h1111_2222;
    step();
    chk("b2b_word1", {32'd0, BusMuxIn}, 64'h11112222);
    mem_ready = 0;
    step();
    chk("b2b_addr2", {55'd0, mem_addr}, 64'h004);
    rd_start = 0; mem_ready = 1; mem_rdata = 32'h3333_4444;
    step();
    chk("b2b_word2", {32'd0, BusMuxIn}, 64'h33334444);
    idle_inputs();
    step();

    // Reset in the middle of a read, then a normal read.
    rd_start = 1; rd_addr = 9'h1FF;
    step();
    rd_start = 0;
    step();
    clear = 0;
    step();
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    chk("midreset_mdr", {32'd0, BusMuxIn}, 64'd0);
    clear = 1; rd_start = 1; rd_addr = 9'h077;
    step();
    rd_start = 0; mem_ready = 1; mem_rdata = 32'h0BAD_CAFE;
    step();
    chk("after_reset_read", {32'd0, BusMuxIn}, 64'h0BADCAFE);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      clear     = ($urandom_range(0, 199) != 0);
      rd_start  = ($urandom_range(0, 3) == 0);
      rd_addr   = AW'($urandom);
      bus_load  = ($urandom_range(0, 2) == 0);
      BusMuxOut = $urandom;
      mem_ready = ($urandom_range(0, 5) == 0);
      mem_rdata = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
